// File: rtl/mips_fetch_stage.sv
// rtl/mips_fetch_stage.sv - MIPS IF stage: PC, 2-bit BHT branch prediction, jump predecode, IF/ID latch
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0040_0000,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        ex_resolve_valid,
    input  logic [31:0] ex_resolve_pc,
    input  logic        ex_resolve_taken,
    input  logic        ex_mispredict,
    input  logic [31:0] ex_correct_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target
);
    localparam int IW = $clog2(BHT_ENTRIES);

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    logic [31:0]   pc;
    logic [1:0]    bht [BHT_ENTRIES];
    logic [IW-1:0] lookup_idx;
    logic [IW-1:0] update_idx;
    logic [1:0]    update_ctr;
    logic [31:0]   pc_plus4;
    logic [31:0]   branch_target;
    logic [31:0]   jump_target;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          unused_resolve_bits;

    assign imem_addr           = pc;
    assign lookup_idx          = pc[IW+1:2];
    assign update_idx          = ex_resolve_pc[IW+1:2];
    assign unused_resolve_bits = ^{ex_resolve_pc[31:IW+2], ex_resolve_pc[1:0]};

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {{14{imem_rdata[15]}}, imem_rdata[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], imem_rdata[25:0], 2'b00};

    // Predecode; the BHT read here sees the pre-update counter value.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_plus4;
        case (imem_rdata[31:26])
            OP_BEQ, OP_BNE: begin
                pred_taken = bht[lookup_idx][1];
                if (pred_taken) begin
                    pred_target = branch_target;
                end
            end
            OP_J, OP_JAL: begin
                pred_taken  = 1'b1;
                pred_target = jump_target;
            end
            default: begin
                pred_taken  = 1'b0;
                pred_target = pc_plus4;
            end
        endcase
    end

    always_comb begin
        update_ctr = bht[update_idx];
        if (ex_resolve_taken) begin
            if (update_ctr != 2'b11) begin
                update_ctr = update_ctr + 2'b01;
            end
        end else begin
            if (update_ctr != 2'b00) begin
                update_ctr = update_ctr - 2'b01;
            end
        end
    end

    // A flush clears only if_valid; the rest of the latch keeps its contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_valid       <= 1'b0;
            if_instr       <= 32'h0;
            if_pc          <= 32'h0;
            if_pred_taken  <= 1'b0;
            if_pred_target <= 32'h0;
        end else if (ex_mispredict) begin
            pc       <= ex_correct_pc;
            if_valid <= 1'b0;
        end else if (!stall) begin
            pc             <= pred_target;
            if_valid       <= 1'b1;
            if_instr       <= imem_rdata;
            if_pc          <= pc;
            if_pred_taken  <= pred_taken;
            if_pred_target <= pred_target;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (ex_resolve_valid) begin
            bht[update_idx] <= update_ctr;
        end
    end
endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb/tb_mips_fetch_stage.sv - directed self-checking bench for mips_fetch_stage
module tb_mips_fetch_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        ex_resolve_valid;
    logic [31:0] ex_resolve_pc;
    logic        ex_resolve_taken;
    logic        ex_mispredict;
    logic [31:0] ex_correct_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;

    logic [31:0] mem [256];
    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } vec_t;

    vec_t vecs [7];

    mips_fetch_stage #(.RESET_PC(32'h0040_0000), .BHT_ENTRIES(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .ex_resolve_valid(ex_resolve_valid),
        .ex_resolve_pc   (ex_resolve_pc),
        .ex_resolve_taken(ex_resolve_taken),
        .ex_mispredict   (ex_mispredict),
        .ex_correct_pc   (ex_correct_pc),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pred_taken   (if_pred_taken),
        .if_pred_target  (if_pred_target)
    );

    always #5 clock = ~clock;

    assign imem_rdata = mem[imem_addr[9:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        ex_mispredict = 1'b1;
        ex_correct_pc = pc;
        step();
        ex_mispredict = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input int n);
        ex_resolve_valid = 1'b1;
        ex_resolve_pc    = pc;
        ex_resolve_taken = taken;
        for (int i = 0; i < n; i++) step();
        ex_resolve_valid = 1'b0;
    endtask

    task automatic fetch_check(input string name, input logic [31:0] pc, input logic [31:0] instr,
                               input logic taken, input logic [31:0] target);
        mem[pc[9:2]] = instr;
        redirect(pc);
        chk({name, ".redir_addr"}, imem_addr, pc);
        chk({name, ".redir_valid"}, {31'b0, if_valid}, 32'd0);
        step();
        chk({name, ".next_addr"}, imem_addr, target);
        chk({name, ".valid"}, {31'b0, if_valid}, 32'd1);
        chk({name, ".if_pc"}, if_pc, pc);
        chk({name, ".if_instr"}, if_instr, instr);
        chk({name, ".taken"}, {31'b0, if_pred_taken}, {31'b0, taken});
        chk({name, ".target"}, if_pred_target, target);
    endtask

    initial begin
        vecs[0] = '{32'h0040_0010, 32'h1000_0003, 1'b0, 32'h0040_0014};
        vecs[1] = '{32'h0040_0000, 32'h0810_0040, 1'b1, 32'h0040_0100};
        vecs[2] = '{32'h0040_0020, 32'h0C10_0010, 1'b1, 32'h0040_0040};
        vecs[3] = '{32'h0040_0030, 32'h1400_FFFF, 1'b0, 32'h0040_0034};
        vecs[4] = '{32'h0040_0040, 32'h2001_0005, 1'b0, 32'h0040_0044};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[6] = '{32'hF000_0000, 32'h0800_0004, 1'b1, 32'hF000_0010};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b1;
        stall = 1'b0;
        ex_resolve_valid = 1'b0;
        ex_resolve_pc = 32'h0;
        ex_resolve_taken = 1'b0;
        ex_mispredict = 1'b0;
        ex_correct_pc = 32'h0;

        // Reset and first fetches
        step();
        step();
        chk("rst.addr", imem_addr, 32'h0040_0000);
        chk("rst.valid", {31'b0, if_valid}, 32'd0);
        chk("rst.instr", if_instr, 32'd0);
        chk("rst.pc", if_pc, 32'd0);
        chk("rst.taken", {31'b0, if_pred_taken}, 32'd0);
        chk("rst.target", if_pred_target, 32'd0);
        reset = 1'b0;
        chk("run0.addr", imem_addr, 32'h0040_0000);
        step();
        chk("run1.addr", imem_addr, 32'h0040_0004);
        chk("run1.valid", {31'b0, if_valid}, 32'd1);
        chk("run1.pc", if_pc, 32'h0040_0000);
        step();
        chk("run2.addr", imem_addr, 32'h0040_0008);
        chk("run2.pc", if_pc, 32'h0040_0004);

        // Predecode vectors with fresh counters
        for (int i = 0; i < 7; i++) begin
            fetch_check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].taken, vecs[i].target);
        end

        // Trained beq
        resolve(32'h0040_0010, 1'b1, 2);
        fetch_check("beq_trained", 32'h0040_0010, 32'h1000_0003, 1'b1, 32'h0040_0020);

        // Self-loop branch: imm = -1 gives target = PC
        resolve(32'h0040_0050, 1'b1, 3);
        fetch_check("beq_self", 32'h0040_0050, 32'h1000_FFFF, 1'b1, 32'h0040_0050);

        // Stall hold, then flush during stall
        mem[8'h18] = 32'h0000_0000;
        redirect(32'h0040_0060);
        step();
        stall = 1'b1;
        step();
        chk("stall1.addr", imem_addr, 32'h0040_0064);
        chk("stall1.valid", {31'b0, if_valid}, 32'd1);
        chk("stall1.pc", if_pc, 32'h0040_0060);
        chk("stall1.target", if_pred_target, 32'h0040_0064);
        ex_mispredict = 1'b1;
        ex_correct_pc = 32'h0040_0080;
        step();
        ex_mispredict = 1'b0;
        chk("stall2.flush_addr", imem_addr, 32'h0040_0080);
        chk("stall2.flush_valid", {31'b0, if_valid}, 32'd0);
        step();
        chk("stall3.addr", imem_addr, 32'h0040_0080);
        chk("stall3.valid", {31'b0, if_valid}, 32'd0);
        chk("stall3.pc", if_pc, 32'h0040_0060);
        stall = 1'b0;

        // Saturation on index 4 (0x400090 aliases 0x400010)
        resolve(32'h0040_0090, 1'b0, 5);
        fetch_check("sat_nt5", 32'h0040_0090, 32'h1000_0001, 1'b0, 32'h0040_0094);
        resolve(32'h0040_0090, 1'b1, 1);
        fetch_check("sat_t1", 32'h0040_0090, 32'h1000_0001, 1'b0, 32'h0040_0094);
        resolve(32'h0040_0090, 1'b1, 1);
        fetch_check("sat_t2", 32'h0040_0090, 32'h1000_0001, 1'b1, 32'h0040_0098);
        resolve(32'h0040_0090, 1'b1, 2);
        resolve(32'h0040_0090, 1'b0, 1);
        fetch_check("sat_top_nt1", 32'h0040_0090, 32'h1000_0001, 1'b1, 32'h0040_0098);
        resolve(32'h0040_0090, 1'b0, 1);
        fetch_check("sat_top_nt2", 32'h0040_0090, 32'h1000_0001, 1'b0, 32'h0040_0094);

        // Same-index lookup and update in one cycle: lookup sees old counter
        mem[8'h28] = 32'h1000_0002;
        redirect(32'h0040_00A0);
        ex_resolve_valid = 1'b1;
        ex_resolve_pc    = 32'h0040_00A0;
        ex_resolve_taken = 1'b1;
        step();
        ex_resolve_valid = 1'b0;
        chk("bypass.taken", {31'b0, if_pred_taken}, 32'd0);
        chk("bypass.addr", imem_addr, 32'h0040_00A4);
        fetch_check("bypass_after", 32'h0040_00A0, 32'h1000_0002, 1'b1, 32'h0040_00AC);
        resolve(32'h0040_00A0, 1'b1, 1);

        // Mispredict without resolve leaves BHT alone
        ex_mispredict = 1'b1;
        ex_correct_pc = 32'h0040_00A0;
        step();
        step();
        ex_mispredict = 1'b0;

        // Asynchronous reset mid-cycle while stalled
        mem[0] = 32'h0;
        stall = 1'b1;
        step();
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("areset.addr", imem_addr, 32'h0040_0000);
        chk("areset.valid", {31'b0, if_valid}, 32'd0);
        chk("areset.pc", if_pc, 32'd0);
        chk("areset.instr", if_instr, 32'd0);
        chk("areset.taken", {31'b0, if_pred_taken}, 32'd0);
        step();
        reset = 1'b0;
        stall = 1'b0;
        step();
        chk("resume.addr", imem_addr, 32'h0040_0004);
        chk("resume.valid", {31'b0, if_valid}, 32'd1);
        chk("resume.pc", if_pc, 32'h0040_0000);
        fetch_check("bht_cleared", 32'h0040_00A0, 32'h1000_0002, 1'b0, 32'h0040_00A4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
Instruction-fetch (IF) stage of the five-stage pipelined MIPS core. It owns the PC, reads the instruction memory and predicts control flow. Conditional branches use a 2-bit saturating-counter branch history table (BHT); jumps are decoded and always taken. It registers the IF/ID pipeline latch that feeds decode, and it accepts stall and mispredict-redirect inputs from the hazard/execute logic.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.
BHT_ENTRIES, 16, number of 2-bit counters; power of two, minimum 2.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
imem_addr  out  32  byte address of the fetch; always equals the current PC
imem_rdata  in  32  instruction at imem_addr; combinational read, valid in the same cycle
stall  in  1  hazard unit request to hold the PC and the IF/ID latch
ex_resolve_valid  in  1  a conditional branch resolved in EX this cycle
ex_resolve_pc  in  32  PC of the resolved branch
ex_resolve_taken  in  1  actual outcome of the resolved branch
ex_mispredict  in  1  prediction was wrong; redirect and flush
ex_correct_pc  in  32  PC to fetch next when ex_mispredict is high
if_valid  out  1  IF/ID latch holds a live instruction
if_instr  out  32  latched instruction
if_pc  out  32  PC of the latched instruction
if_pred_taken  out  1  fetch predicted taken
if_pred_target  out  32  predicted next PC (PC+4 when not taken)

Behaviour:
- Reset (async): PC=RESET_PC. if_valid=0, if_instr=0 (NOP), if_pc=0, if_pred_taken=0, if_pred_target=0. All BHT counters=2'b01 (weakly not-taken). Deasserting reset mid-operation restarts fetch at RESET_PC.
- BHT index = PC[log2(BHT_ENTRIES)+1:2]. No tag check. Aliasing is allowed.
- Predecode of imem_rdata (opcode = bits 31:26):
  - beq (6'h04) / bne (6'h05): taken if counter[1]=1. Target = PC+4 + (sign-extended imm16 << 2).
  - j (6'h02) / jal (6'h03): always taken. Target = {(PC+4)[31:28], imm26, 2'b00}.
  - All other opcodes: not taken. Next PC = PC+4.
- All PC arithmetic is modulo 2^32; wrap-around from 32'hFFFF_FFFC to 0 is legal.
- Next-state priority per cycle:
  1. ex_mispredict=1: PC<=ex_correct_pc; if_valid<=0. The flush overrides stall.
  2. Else stall=1: PC and the whole IF/ID latch hold their values.
  3. Else: PC<=predicted next PC. Latch <= {valid=1, imem_rdata, PC, pred_taken, pred_target}.
- Latency: an instruction is presented to decode one cycle after its PC is on imem_addr. The first valid fetch appears in the cycle after reset deasserts.
- BHT update happens on ex_resolve_valid, independent of stall and mispredict:
  - Counter indexed by ex_resolve_pc increments toward 2'b11 if taken, decrements toward 2'b00 if not taken.
  - Counters saturate at 2'b00 and 2'b11.
- If a lookup and an update hit the same index in one cycle, the lookup sees the old counter value (no bypass).
- ex_mispredict without ex_resolve_valid (for example a jump-register redirect) redirects the PC but leaves the BHT unchanged.

Test Plan:
- Reset, then 3 cycles with stall=0 and memory holding NOPs: imem_addr = 0x400000, 0x400004, 0x400008. if_valid rises one cycle after reset drops, with if_pc=0x400000.
- beq with imm=0x0003 at 0x400010, counters fresh: predicted not taken, next PC 0x400014. Two taken resolves for that PC, then refetch: if_pred_taken=1 and next PC=0x400020.
- j with imm26=0x0100040 at 0x400000: next imem_addr=0x400100, if_pred_taken=1, no BHT change. Same test with imm16=0xFFFF on beq (counter forced to 2'b11): target = PC.
- stall=1 for 3 cycles: imem_addr and all if_* outputs stay constant. Asserting ex_mispredict=1 with ex_correct_pc=0x400080 in the second stalled cycle: next imem_addr=0x400080 and if_valid=0.
- Saturation: 4 not-taken resolves on one index leave its counter at 2'b00, and a fifth keeps it there. 4 taken resolves then read 2'b11.
- Assert reset asynchronously mid-cycle while stalled: outputs clear immediately, without waiting for a clock edge, and fetch resumes at 0x400000.
